// File: rtl/multi_phase_driver_pkg.sv
// multi_phase_driver_pkg: shared channel state encoding and default widths
package multi_phase_driver_pkg;

    localparam int DUTY_CYCLE_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        FLOAT = 2'd0,
        DEAD  = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_t;

endpackage

// File: rtl/phase_dead_time_channel.sv
// phase_dead_time_channel: one half-bridge with dead-time on every side switch
module phase_dead_time_channel
    import multi_phase_driver_pkg::*;
#(
    parameter int DEAD_TIME = 2,
    parameter int DT_WIDTH  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  chan_state_t target,
    output logic        pwm_high,
    output logic        pwm_low
);

    localparam logic [DT_WIDTH-1:0] DT_LOAD = DT_WIDTH'(DEAD_TIME - 1);

    chan_state_t           state, state_nxt;
    logic [DT_WIDTH-1:0]   dt_cnt, dt_nxt;

    // float wins at once; a dead window always runs to expiry, then takes the current target
    always_comb begin
        state_nxt = state;
        dt_nxt    = dt_cnt;
        if (target == FLOAT) begin
            state_nxt = FLOAT;
        end else if (state == DEAD) begin
            if (dt_cnt == '0) state_nxt = target;
            else dt_nxt = dt_cnt - DT_WIDTH'(1);
        end else if (state != target) begin
            state_nxt = DEAD;
            dt_nxt    = DT_LOAD;
        end
    end

    // state and registered gate drives updated together so the pins never glitch
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= FLOAT;
            dt_cnt   <= '0;
            pwm_high <= 1'b0;
            pwm_low  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dt_cnt   <= dt_nxt;
            pwm_high <= (state_nxt == HIGH);
            pwm_low  <= (state_nxt == LOW);
        end
    end

endmodule

// File: rtl/multi_phase_driver.sv
// multi_phase_driver: N-phase complementary PWM with shared counter and buffered duties
module multi_phase_driver
    import multi_phase_driver_pkg::*;
#(
    parameter int NUM_PHASES       = 3,
    parameter int DUTY_CYCLE_WIDTH = DUTY_CYCLE_WIDTH_DEF,
    parameter int DEAD_TIME        = 2,
    parameter int DT_WIDTH         = 4
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [NUM_PHASES*DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    input  logic                                   duty_valid,
    input  logic [NUM_PHASES-1:0]                  high_z,
    output logic [NUM_PHASES-1:0]                  pwm_high,
    output logic [NUM_PHASES-1:0]                  pwm_low,
    output logic                                   period_start
);

    localparam int W = DUTY_CYCLE_WIDTH;
    localparam logic [W-1:0] CNT_MAX = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0]            counter;
    logic [NUM_PHASES*W-1:0] shadow, active;
    chan_state_t             target [NUM_PHASES];

    // shared period counter 0..2^W-2; period_start carries the same one-clock lag as the pins
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            counter      <= '0;
            period_start <= 1'b0;
        end else begin
            counter      <= (counter == CNT_MAX) ? '0 : counter + W'(1);
            period_start <= (counter == '0);
        end
    end

    // double-buffered duties; a strobe on the last count bypasses the shadow
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (duty_valid) shadow <= duty_cycle;
            if (counter == CNT_MAX) active <= duty_valid ? duty_cycle : shadow;
        end
    end

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ph
        assign target[k] = high_z[k] ? FLOAT : ((counter < active[k*W +: W]) ? HIGH : LOW);

        phase_dead_time_channel #(
            .DEAD_TIME (DEAD_TIME),
            .DT_WIDTH  (DT_WIDTH)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .target   (target[k]),
            .pwm_high (pwm_high[k]),
            .pwm_low  (pwm_low[k])
        );
    end

endmodule

// File: tb/tb_multi_phase_driver.sv
// tb_multi_phase_driver: timestamp model plus hand-computed period measurements
module tb_multi_phase_driver;

    localparam int NP  = 3;
    localparam int W   = 8;
    localparam int DT  = 2;
    localparam int PER = 255;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NP*W-1:0] duty_cycle;
    logic            duty_valid;
    logic [NP-1:0]   high_z;
    logic [NP-1:0]   pwm_high, pwm_low;
    logic            period_start;

    int vectors = 0;
    int miscompares = 0;

    multi_phase_driver #(
        .NUM_PHASES       (NP),
        .DUTY_CYCLE_WIDTH (W),
        .DEAD_TIME        (DT),
        .DT_WIDTH         (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .duty_cycle   (duty_cycle),
        .duty_valid   (duty_valid),
        .high_z       (high_z),
        .pwm_high     (pwm_high),
        .pwm_low      (pwm_low),
        .period_start (period_start)
    );

    always #5 clock = ~clock;

    // model: side 0=off 1=high 2=low; a dead window is a time stamp when driving may resume
    int            m_cnt, m_cyc;
    int            m_shadow [NP];
    int            m_active [NP];
    int            m_side   [NP];
    int            m_dend   [NP];
    bit            m_dead   [NP];
    logic [NP-1:0] exp_high, exp_low;
    logic          exp_ps;
    bit            model_on = 1'b0;

    task automatic model_step();
        int tgt;
        if (!reset_n) begin
            m_cnt = 0;
            for (int k = 0; k < NP; k++) begin
                m_shadow[k] = 0; m_active[k] = 0; m_side[k] = 0; m_dead[k] = 0; m_dend[k] = 0;
            end
            exp_high = '0; exp_low = '0; exp_ps = 1'b0;
            model_on = 1'b1;
        end else begin
            for (int k = 0; k < NP; k++) begin
                tgt = high_z[k] ? 0 : ((m_cnt < m_active[k]) ? 1 : 2);
                if (tgt == 0) begin
                    m_side[k] = 0; m_dead[k] = 0;
                end else if (m_dead[k]) begin
                    if (m_cyc >= m_dend[k]) begin m_dead[k] = 0; m_side[k] = tgt; end
                end else if (m_side[k] != tgt) begin
                    m_dead[k] = 1; m_side[k] = 0; m_dend[k] = m_cyc + DT;
                end
                exp_high[k] = (m_side[k] == 1);
                exp_low[k]  = (m_side[k] == 2);
            end
            exp_ps = (m_cnt == 0);
            for (int k = 0; k < NP; k++) begin
                if (m_cnt == PER - 1) m_active[k] = duty_valid ? int'(duty_cycle[k*W +: W]) : m_shadow[k];
                if (duty_valid) m_shadow[k] = int'(duty_cycle[k*W +: W]);
            end
            m_cnt = (m_cnt + 1) % PER;
        end
        m_cyc = m_cyc + 1;
    endtask

    initial m_cyc = 0;
    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (model_on) begin
            vectors++;
            if (pwm_high !== exp_high || pwm_low !== exp_low || period_start !== exp_ps) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t high=%b want %b low=%b want %b ps=%b want %b",
                         $time, pwm_high, exp_high, pwm_low, exp_low, period_start, exp_ps);
            end
            vectors++;
            if ((pwm_high & pwm_low) !== '0) begin
                miscompares++;
                $display("FAIL overlap t=%0t high=%b low=%b want no common bit", $time, pwm_high, pwm_low);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_ps();
        int n = 0;
        @(negedge clock);
        while (period_start !== 1'b1 && n < 600) begin
            @(negedge clock);
            n++;
        end
        chk("wait_period_start_timeout", int'(period_start === 1'b1), 1);
    endtask

    // starts on a period_start sample, returns on the next one; counts phase 0
    task automatic measure(input int pulse_at, input logic [NP*W-1:0] pd,
                           output int hi, output int lo, output int ps);
        hi = 0; lo = 0; ps = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == pulse_at) begin
                duty_cycle = pd;
                duty_valid = 1'b1;
            end else begin
                duty_valid = 1'b0;
            end
            hi += int'(pwm_high[0]);
            lo += int'(pwm_low[0]);
            ps += int'(period_start);
            @(negedge clock);
        end
        duty_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, ps;
        reset_n = 1'b0; duty_cycle = '0; duty_valid = 1'b0; high_z = '0;
        repeat (3) @(negedge clock);
        chk("reset_high", int'(pwm_high), 0);
        chk("reset_low", int'(pwm_low), 0);
        chk("reset_ps", int'(period_start), 0);

        reset_n = 1'b1;
        @(negedge clock);
        chk("t1_first_ps", int'(period_start), 1);
        chk("t1_dead0_low", int'(pwm_low), 0);
        @(negedge clock);
        chk("t1_dead1_low", int'(pwm_low), 0);
        @(negedge clock);
        chk("t1_low_on", int'(pwm_low), 7);
        chk("t1_high_off", int'(pwm_high), 0);

        duty_cycle = {8'h00, 8'h00, 8'h10}; duty_valid = 1'b1;
        @(negedge clock);
        duty_valid = 1'b0;
        wait_ps();
        chk("t2_lead_dead", int'(pwm_high[0] | pwm_low[0]), 0);
        measure(100, {8'h00, 8'h00, 8'hFF}, hi, lo, ps);
        chk("t2_high_cycles", hi, 14);
        chk("t2_low_cycles", lo, 237);
        chk("t2_ps_count", ps, 1);

        measure(-1, '0, hi, lo, ps);
        chk("t3_ff_first_high", hi, 253);
        measure(100, {8'h00, 8'h00, 8'h01}, hi, lo, ps);
        chk("t3_ff_high", hi, 255);
        chk("t3_ff_low", lo, 0);
        measure(-1, '0, hi, lo, ps);
        measure(100, {8'h00, 8'h00, 8'h10}, hi, lo, ps);
        chk("t3_d1_high", hi, 0);
        chk("t3_d1_low", lo, 253);

        measure(100, {8'h00, 8'h80, 8'h80}, hi, lo, ps);
        chk("t4_mid_unchanged_high", hi, 14);
        chk("t4_mid_unchanged_low", lo, 237);
        measure(253, {8'h00, 8'h80, 8'h40}, hi, lo, ps);
        chk("t4_80_high", hi, 126);
        chk("t4_80_low", lo, 125);
        measure(-1, '0, hi, lo, ps);
        chk("t4_bypass_high", hi, 62);
        chk("t4_bypass_low", lo, 189);

        repeat (10) @(negedge clock);
        chk("t5_ph1_high_before", int'(pwm_high[1]), 1);
        high_z = 3'b010;
        @(negedge clock);
        chk("t5_float_high", int'(pwm_high[1]), 0);
        chk("t5_float_low", int'(pwm_low[1]), 0);
        repeat (3) @(negedge clock);
        high_z = 3'b000;
        @(negedge clock);
        chk("t5_dead0", int'(pwm_high[1] | pwm_low[1]), 0);
        @(negedge clock);
        chk("t5_dead1", int'(pwm_high[1] | pwm_low[1]), 0);
        @(negedge clock);
        chk("t5_high_back", int'(pwm_high[1]), 1);

        wait_ps();
        chk("t6_in_dead", int'(pwm_high[0] | pwm_low[0]), 0);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t6_rst_outs", int'({pwm_high, pwm_low}), 0);
            chk("t6_rst_ps", int'(period_start), 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        chk("t6_restart_ps", int'(period_start), 1);
        chk("t6_restart_dead", int'(pwm_low), 0);
        repeat (2) @(negedge clock);
        chk("t6_low_after", int'(pwm_low), 7);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
